// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I decode types, opcodes and the ID/EX register layout
package riscv_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    // IMM_NONE covers R-type and unsupported encodings, which carry no immediate
    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J
    } imm_src_e;

    typedef struct packed {
        logic              reg_write;
        logic              mem_write;
        logic              jump;
        logic              branch;
        logic              alu_src;
        result_src_e       result_src;
        alu_ctrl_e         alu_control;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm_ext;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc_plus4;
    } idex_t;

endpackage

// File: rtl/reg_file.sv
// reg_file: 32x32 register file, two async reads with write-first bypass, one sync write, x0 reads zero
module reg_file
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            srst,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [NUM_REGS-1:0][XLEN-1:0] regs_q, regs_d;

    // Apply the write-back port; x0 is never written so it stays zero after reset
    always_comb begin
        regs_d = regs_q;
        if (we && wa != '0) regs_d[wa] = wd;
    end

    // Register array with synchronous clear
    always_ff @(posedge clk) regs_q <= srst ? '0 : regs_d;

    assign rd1 = ra1 == '0 ? '0 : (we && wa == ra1) ? wd : regs_q[ra1];
    assign rd2 = ra2 == '0 ? '0 : (we && wa == ra2) ? wd : regs_q[ra2];

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I ID stage (regfile, control decode, imm extend, ID/EX register); DECODE_ILLEGAL_DET_EN adds illegal_e
module decode_stage
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        srst,
    input  logic        flush_e,
    input  logic [31:0] instr_d,
    input  logic [31:0] pc_d,
    input  logic [31:0] pc_plus4_d,
    input  logic        reg_write_w,
    input  logic [4:0]  rd_w,
    input  logic [31:0] result_w,
    output logic [4:0]  rs1_d,
    output logic [4:0]  rs2_d,
    output logic        reg_write_e,
    output logic        mem_write_e,
    output logic        jump_e,
    output logic        branch_e,
    output logic        alu_src_e,
    output logic [1:0]  result_src_e,
    output logic [2:0]  alu_control_e,
    output logic [31:0] rd1_e,
    output logic [31:0] rd2_e,
    output logic [31:0] imm_ext_e,
    output logic [4:0]  rs1_e,
    output logic [4:0]  rs2_e,
    output logic [4:0]  rd_e,
    output logic [31:0] pc_e,
    output logic [31:0] pc_plus4_e
`ifdef DECODE_ILLEGAL_DET_EN
    ,
    output logic        illegal_e
`endif
);

    logic [XLEN-1:0] rd1_d, rd2_d;
    logic            alu_ok;
    alu_ctrl_e       alu_op;
    imm_src_e        imm_src;
    idex_t           dec, idex_d, idex_q;

    assign rs1_d = instr_d[19:15];
    assign rs2_d = instr_d[24:20];

    reg_file u_reg_file (
        .clk  (clk),
        .srst (srst),
        .we   (reg_write_w),
        .wa   (rd_w),
        .wd   (result_w),
        .ra1  (rs1_d),
        .ra2  (rs2_d),
        .rd1  (rd1_d),
        .rd2  (rd2_d)
    );

    // ALU operation for R/I-type by funct3; instr_d[30] selects sub only for R-type add
    always_comb begin
        alu_ok = instr_d[14:12] inside {3'b000, 3'b010, 3'b110, 3'b111};
        alu_op = instr_d[14:12] == 3'b010 ? ALU_SLT :
                 instr_d[14:12] == 3'b110 ? ALU_OR  :
                 instr_d[14:12] == 3'b111 ? ALU_AND :
                 (instr_d[6:0] == OP_R && instr_d[30]) ? ALU_SUB : ALU_ADD;
    end

    // Main decode; unsupported opcode/funct3 leaves every control at zero
    always_comb begin
        dec     = '0;
        imm_src = IMM_NONE;
        case (instr_d[6:0])
            OP_LW: if (instr_d[14:12] == 3'b010) begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = RES_MEM;
                imm_src        = IMM_I;
            end
            OP_SW: if (instr_d[14:12] == 3'b010) begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                imm_src       = IMM_S;
            end
            OP_BEQ: if (instr_d[14:12] == 3'b000) begin
                dec.branch      = 1'b1;
                dec.alu_control = ALU_SUB;
                imm_src         = IMM_B;
            end
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.result_src = RES_PC4;
                imm_src        = IMM_J;
            end
            OP_R: if (alu_ok) begin
                dec.reg_write   = 1'b1;
                dec.alu_control = alu_op;
            end
            OP_I: if (alu_ok) begin
                dec.reg_write   = 1'b1;
                dec.alu_src     = 1'b1;
                dec.alu_control = alu_op;
                imm_src         = IMM_I;
            end
            default: ;
        endcase
        dec.imm_ext  = imm_src == IMM_I ? {{20{instr_d[31]}}, instr_d[31:20]} :
                       imm_src == IMM_S ? {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]} :
                       imm_src == IMM_B ? {{20{instr_d[31]}}, instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0} :
                       imm_src == IMM_J ? {{12{instr_d[31]}}, instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0} : '0;
        dec.rd1      = rd1_d;
        dec.rd2      = rd2_d;
        dec.rs1      = rs1_d;
        dec.rs2      = rs2_d;
        dec.rd       = instr_d[11:7];
        dec.pc       = pc_d;
        dec.pc_plus4 = pc_plus4_d;
        idex_d       = flush_e ? idex_t'('0) : dec;
    end

    // ID/EX register; reset dominates flush
    always_ff @(posedge clk) idex_q <= srst ? '0 : idex_d;

    assign reg_write_e   = idex_q.reg_write;
    assign mem_write_e   = idex_q.mem_write;
    assign jump_e        = idex_q.jump;
    assign branch_e      = idex_q.branch;
    assign alu_src_e     = idex_q.alu_src;
    assign result_src_e  = idex_q.result_src;
    assign alu_control_e = idex_q.alu_control;
    assign rd1_e         = idex_q.rd1;
    assign rd2_e         = idex_q.rd2;
    assign imm_ext_e     = idex_q.imm_ext;
    assign rs1_e         = idex_q.rs1;
    assign rs2_e         = idex_q.rs2;
    assign rd_e          = idex_q.rd;
    assign pc_e          = idex_q.pc;
    assign pc_plus4_e    = idex_q.pc_plus4;

`ifdef DECODE_ILLEGAL_DET_EN
    logic illegal_d, illegal_q;

    // Flag nonzero encodings outside the supported set; funct7 must be 0, or 0100000 for sub
    always_comb begin
        illegal_d = !flush_e && instr_d != '0 && !(
            (instr_d[6:0] == OP_LW  && instr_d[14:12] == 3'b010) ||
            (instr_d[6:0] == OP_SW  && instr_d[14:12] == 3'b010) ||
            (instr_d[6:0] == OP_BEQ && instr_d[14:12] == 3'b000) ||
            (instr_d[6:0] == OP_JAL) ||
            (instr_d[6:0] == OP_I   && alu_ok) ||
            (instr_d[6:0] == OP_R   && alu_ok && (instr_d[31:25] == 7'b0000000 ||
                                                  (instr_d[31:25] == 7'b0100000 && instr_d[14:12] == 3'b000))));
    end

    // Illegal flag travels with the instruction into EX
    always_ff @(posedge clk) illegal_q <= srst ? 1'b0 : illegal_d;

    assign illegal_e = illegal_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a spec-level reference model
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        srst, flush_e, reg_write_w;
    logic [31:0] instr_d, pc_d, pc_plus4_d, result_w;
    logic [4:0]  rd_w, rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
    logic        reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e;
    logic [1:0]  result_src_e;
    logic [2:0]  alu_control_e;
    logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
`ifdef DECODE_ILLEGAL_DET_EN
    logic        illegal_e;
`endif

    decode_stage dut (
        .clk           (clk),
        .srst          (srst),
        .flush_e       (flush_e),
        .instr_d       (instr_d),
        .pc_d          (pc_d),
        .pc_plus4_d    (pc_plus4_d),
        .reg_write_w   (reg_write_w),
        .rd_w          (rd_w),
        .result_w      (result_w),
        .rs1_d         (rs1_d),
        .rs2_d         (rs2_d),
        .reg_write_e   (reg_write_e),
        .mem_write_e   (mem_write_e),
        .jump_e        (jump_e),
        .branch_e      (branch_e),
        .alu_src_e     (alu_src_e),
        .result_src_e  (result_src_e),
        .alu_control_e (alu_control_e),
        .rd1_e         (rd1_e),
        .rd2_e         (rd2_e),
        .imm_ext_e     (imm_ext_e),
        .rs1_e         (rs1_e),
        .rs2_e         (rs2_e),
        .rd_e          (rd_e),
        .pc_e          (pc_e),
        .pc_plus4_e    (pc_plus4_e)
`ifdef DECODE_ILLEGAL_DET_EN
        ,
        .illegal_e     (illegal_e)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw, mw, jmp, br, asrc;
        logic [1:0]  rsrc;
        logic [2:0]  ac;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] pc, pc4;
        logic        ill;
    } exp_t;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] rf [32];
    exp_t        exp_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) $display("FAIL %s got=%h exp=%h t=%0t", tag, got, want, $time);
        else n_pass++;
    endtask

    function automatic logic [31:0] rd_model(input logic [4:0] a, input logic we, input logic [4:0] wa, input logic [31:0] wd);
        if (a == 0) return 32'd0;
        if (we && wa == a) return wd;
        return rf[a];
    endfunction

    // Reference decode written from the ISA rules
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b);
        exp_t        e = '0;
        logic [6:0]  op = ins[6:0];
        logic [2:0]  f3 = ins[14:12];
        logic [6:0]  f7 = ins[31:25];
        logic        legal = 1'b0;
        logic        alu_f3 = (f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd6 || f3 == 3'd7);
        logic [31:0] imm_i = 32'($signed(ins[31:20]));
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd  = ins[11:7];
        e.rd1 = a;
        e.rd2 = b;
        e.pc  = pc;
        e.pc4 = pc + 32'd4;
        if (op == 7'h03 && f3 == 3'd2) begin
            e.rw = 1; e.asrc = 1; e.rsrc = 2'd1; e.imm = imm_i; legal = 1;
        end
        if (op == 7'h23 && f3 == 3'd2) begin
            e.mw = 1; e.asrc = 1; e.imm = 32'($signed({ins[31:25], ins[11:7]})); legal = 1;
        end
        if (op == 7'h63 && f3 == 3'd0) begin
            e.br = 1; e.ac = 3'd1; e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})); legal = 1;
        end
        if (op == 7'h6F) begin
            e.rw = 1; e.jmp = 1; e.rsrc = 2'd2; e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})); legal = 1;
        end
        if ((op == 7'h33 || op == 7'h13) && alu_f3) begin
            e.rw   = 1;
            e.asrc = (op == 7'h13);
            e.imm  = (op == 7'h13) ? imm_i : 32'd0;
            e.ac   = f3 == 3'd2 ? 3'd5 : f3 == 3'd6 ? 3'd3 : f3 == 3'd7 ? 3'd2 : (op == 7'h33 && f7[5]) ? 3'd1 : 3'd0;
            legal  = (op == 7'h13) || f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd0);
        end
        e.ill = (ins != 0) && !legal;
        return e;
    endfunction

    task automatic check_all();
        check("reg_write_e", reg_write_e, exp_q.rw);
        check("mem_write_e", mem_write_e, exp_q.mw);
        check("jump_e", jump_e, exp_q.jmp);
        check("branch_e", branch_e, exp_q.br);
        check("alu_src_e", alu_src_e, exp_q.asrc);
        check("result_src_e", result_src_e, exp_q.rsrc);
        check("alu_control_e", alu_control_e, exp_q.ac);
        check("rd1_e", rd1_e, exp_q.rd1);
        check("rd2_e", rd2_e, exp_q.rd2);
        check("imm_ext_e", imm_ext_e, exp_q.imm);
        check("rs1_e", rs1_e, exp_q.rs1);
        check("rs2_e", rs2_e, exp_q.rs2);
        check("rd_e", rd_e, exp_q.rd);
        check("pc_e", pc_e, exp_q.pc);
        check("pc_plus4_e", pc_plus4_e, exp_q.pc4);
`ifdef DECODE_ILLEGAL_DET_EN
        check("illegal_e", illegal_e, exp_q.ill);
`endif
    endtask

    // One decode cycle: drive, predict, clock, update model regfile, compare
    task automatic step(input logic [31:0] ins, input logic fl, input logic rs,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
        instr_d     = ins;
        flush_e     = fl;
        srst        = rs;
        reg_write_w = we;
        rd_w        = wa;
        result_w    = wd;
        pc_d        = $urandom;
        pc_plus4_d  = pc_d + 32'd4;
        #1;
        check("rs1_d", rs1_d, ins[19:15]);
        check("rs2_d", rs2_d, ins[24:20]);
        exp_q = (rs || fl) ? '0 : model(ins, pc_d, rd_model(ins[19:15], we, wa, wd), rd_model(ins[24:20], we, wa, wd));
        @(posedge clk);
        if (rs) foreach (rf[i]) rf[i] = '0;
        else if (we && wa != 0) rf[wa] = wd;
        #1;
        check_all();
    endtask

    logic [6:0] ops [6] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F};
    logic [2:0] alu_f3s [4] = '{3'd0, 3'd2, 3'd6, 3'd7};

    initial begin
        foreach (rf[i]) rf[i] = '0;
        step($urandom, 1'b1, 1'b1, 1'b1, 5'd3, 32'h55);
        check("reset_rw", reg_write_e, 0);
        check("reset_pc", pc_e, 0);
        for (int i = 1; i < 32; i++) begin
            step({7'b0, 5'(i), 5'(i), 3'b0, 5'd1, 7'b0110011}, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
            check("x_read_after_reset", rd1_e | rd2_e, 0);
        end
        step(32'h00700293, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        check("addi_rd", rd_e, 5);
        check("addi_imm", imm_ext_e, 7);
        check("addi_alusrc", alu_src_e, 1);
        check("addi_alu", alu_control_e, 0);
        step(32'h00528333, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
        check("bypass_rd1", rd1_e, 32'hDEADBEEF);
        check("bypass_rd2", rd2_e, 32'hDEADBEEF);
        step(32'h000000B3, 1'b0, 1'b0, 1'b1, 5'd0, 32'h1234);
        check("x0_bypass", rd1_e, 0);
        step(32'h000000B3, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        check("x0_read", rd1_e, 0);
        step(32'hFE20AE23, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        check("sw_imm", imm_ext_e, 32'hFFFFFFFC);
        check("sw_mw", mem_write_e, 1);
        check("sw_rw", reg_write_e, 0);
        step(32'h008000EF, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        check("jal_imm", imm_ext_e, 8);
        check("jal_jump", jump_e, 1);
        check("jal_rsrc", result_src_e, 2'b10);
        step(32'h00208463, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        check("beq_branch", branch_e, 1);
        step(32'h00208463, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        check("flush_branch", branch_e, 0);
        check("flush_imm", imm_ext_e, 0);
        step(32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        check("illegal_rw", reg_write_e, 0);
`ifdef DECODE_ILLEGAL_DET_EN
        check("illegal_set", illegal_e, 1);
`endif
        step(32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
`ifdef DECODE_ILLEGAL_DET_EN
        check("bubble_not_illegal", illegal_e, 0);
`endif
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ins = $urandom;
            int          r = $urandom_range(0, 9);
            logic        we = $urandom_range(0, 9) < 6;
            logic [4:0]  wa = 5'($urandom);
            if (r < 6) begin
                ins[6:0] = ops[r];
                if ($urandom_range(0, 3) != 0) begin
                    ins[14:12] = (r < 2) ? 3'd2 : (r == 4) ? 3'd0 : alu_f3s[$urandom_range(0, 3)];
                    if (r == 2) ins[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
                end
            end else if (r == 6) ins = 32'h0;
            if ($urandom_range(0, 2) == 0) wa = ins[19:15];
            else if ($urandom_range(0, 3) == 0) wa = ins[24:20];
            step(ins, $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0, we, wa, $urandom);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
